// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX push-port arbiter.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Bits needed to index 'value' items; never less than one.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request strictly after the previous owner, wrapping.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [clog2(NUM_REQ)-1:0] i_last,
    output logic [clog2(NUM_REQ)-1:0] o_idx,
    output logic                      o_any
);

    localparam int GW = clog2(NUM_REQ);

    logic [GW:0]        w_sum  [NUM_REQ];
    logic [GW-1:0]      w_cand [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    // Candidate gi is the requester gi+1 positions after the previous owner.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, i_last} + (GW+1)'(gi + 1);
            assign w_cand[gi] = (w_sum[gi] >= (GW+1)'(NUM_REQ))
                              ? GW'(w_sum[gi] - (GW+1)'(NUM_REQ))
                              : GW'(w_sum[gi]);
            assign w_hit[gi]  = i_req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        o_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_idx = w_cand[k];
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one UART TX FIFO push port.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int MAX_PKT       = 64,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        uart_tx_start,
    output logic [BYTE_W-1:0]           uart_tx_data_in,
    input  logic                        uart_tx_fifo_full,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        busy,
    output logic                        pkt_abort
);

    localparam int          GW         = clog2(NUM_REQ);
    localparam int          SW         = clog2(STALL_TIMEOUT + 1);
    localparam logic [15:0] MAX_CNT    = 16'(MAX_PKT);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);

    state_t        r_state;
    logic [GW-1:0] r_grant_id;
    logic [15:0]   r_byte_cnt;
    logic [SW-1:0] r_stall_cnt;
    logic          r_pkt_abort;

    logic          w_xfer;
    logic          w_g_valid;
    logic          w_g_last;
    logic          w_accept;
    logic [15:0]   w_cnt_inc;
    logic          w_cap;
    logic          w_stall_out;
    logic [GW-1:0] w_pick;
    logic          w_any;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_last (r_grant_id),
        .o_idx  (w_pick),
        .o_any  (w_any)
    );

    assign w_xfer      = (r_state == ST_XFER);
    assign w_g_valid   = req_valid[r_grant_id];
    assign w_g_last    = req_last[r_grant_id];
    assign w_accept    = w_xfer & w_g_valid & ~uart_tx_fifo_full;
    assign w_cnt_inc   = r_byte_cnt + 16'd1;
    assign w_cap       = (w_cnt_inc == MAX_CNT);
    assign w_stall_out = ~w_g_valid & (r_stall_cnt == STALL_LAST);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_xfer & (r_grant_id == GW'(gi)) & ~uart_tx_fifo_full;
        end
    endgenerate

    // Data lane is gated to zero outside XFER so idle traffic never leaks to the UART.
    assign uart_tx_start   = w_accept;
    assign uart_tx_data_in = w_xfer ? req_data[int'(r_grant_id)*BYTE_W +: BYTE_W] : '0;
    assign grant_id        = r_grant_id;
    assign busy            = w_xfer;
    assign pkt_abort       = r_pkt_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= GW'(NUM_REQ - 1);
            r_byte_cnt  <= '0;
            r_stall_cnt <= '0;
            r_pkt_abort <= 1'b0;
        end else begin
            r_pkt_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state     <= ST_XFER;
                        r_grant_id  <= w_pick;
                        r_byte_cnt  <= '0;
                        r_stall_cnt <= '0;
                    end
                end
                ST_XFER: begin
                    if (w_accept) begin
                        r_byte_cnt <= w_cnt_inc;
                    end
                    // A held byte under FIFO backpressure is not a stall.
                    if (w_g_valid) begin
                        r_stall_cnt <= '0;
                    end else if (r_stall_cnt != '1) begin
                        r_stall_cnt <= r_stall_cnt + SW'(1);
                    end
                    if (w_accept && (w_g_last || w_cap)) begin
                        r_state     <= ST_IDLE;
                        r_pkt_abort <= ~w_g_last;
                    end else if (w_stall_out) begin
                        r_state     <= ST_IDLE;
                        r_pkt_abort <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: per-lane byte queues drive requesters, expected UART bytes are popped on each start.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MP = 64;
    localparam int ST = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            uart_tx_start;
    logic [7:0]      uart_tx_data_in;
    logic            uart_tx_fifo_full;
    logic [1:0]      grant_id;
    logic            busy;
    logic            pkt_abort;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [8:0]    lane_q [NR][$];
    logic [7:0]    sb [$];
    int            start_cyc [$];
    int            cyc = 0;
    int            abort_cnt = 0;
    int            abort_cyc = -1;
    logic [NR-1:0] hs_s = '0;
    bit            stall_en [NR];
    int            stall_at [NR];
    int            ff_mode = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .MAX_PKT       (MP),
        .STALL_TIMEOUT (ST)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .uart_tx_start     (uart_tx_start),
        .uart_tx_data_in   (uart_tx_data_in),
        .uart_tx_fifo_full (uart_tx_fifo_full),
        .grant_id          (grant_id),
        .busy              (busy),
        .pkt_abort         (pkt_abort)
    );

    always #10 clk = ~clk;

    // Requester and FIFO-full driver: pops a lane on the handshake seen at the previous negedge.
    initial begin
        logic [8:0] head;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        uart_tx_fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs_s[i] && lane_q[i].size() > 0) begin
                    void'(lane_q[i].pop_front());
                end
                if (lane_q[i].size() > 0 && !(stall_en[i] && lane_q[i].size() == stall_at[i])) begin
                    head = lane_q[i][0];
                    req_valid[i]     = 1'b1;
                    req_data[8*i+:8] = head[7:0];
                    req_last[i]      = head[8];
                end else begin
                    req_valid[i]     = 1'b0;
                    req_data[8*i+:8] = 8'h00;
                    req_last[i]      = 1'b0;
                end
            end
            case (ff_mode)
                1:       uart_tx_fifo_full = ($urandom_range(0, 2) == 0);
                2:       uart_tx_fifo_full = 1'b1;
                default: uart_tx_fifo_full = 1'b0;
            endcase
        end
    end

    // Output monitor: every start is compared against the scoreboard head.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            cyc  = cyc + 1;
            hs_s = req_valid & req_ready;
            if (pkt_abort) begin
                abort_cnt = abort_cnt + 1;
                abort_cyc = cyc;
            end
            if (uart_tx_start) begin
                start_cyc.push_back(cyc);
                vec_cnt = vec_cnt + 1;
                if (uart_tx_fifo_full !== 1'b0) begin
                    err_cnt = err_cnt + 1;
                    $display("FAIL start_while_full: got start=1 full=%b, required no start", uart_tx_fifo_full);
                end
                vec_cnt = vec_cnt + 1;
                if (sb.size() == 0) begin
                    err_cnt = err_cnt + 1;
                    $display("FAIL unexpected_byte: got %h, required no start", uart_tx_data_in);
                end else begin
                    exp_b = sb.pop_front();
                    if (uart_tx_data_in !== exp_b) begin
                        err_cnt = err_cnt + 1;
                        $display("FAIL tx_byte: got %h, required %h", uart_tx_data_in, exp_b);
                    end else begin
                        $display("byte %h accepted at cycle %0d", uart_tx_data_in, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic enqueue(input int lane, input logic [7:0] base, input int n,
                           input bit with_last, input bit to_sb);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = base + 8'(k);
            lane_q[lane].push_back({(with_last && k == n - 1), b});
            if (to_sb) begin
                sb.push_back(b);
            end
        end
    endtask

    task automatic sb_push(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back(base + 8'(k));
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && busy === 1'b0 && lane_q[0].size() == 0 && lane_q[1].size() == 0
                && lane_q[2].size() == 0 && lane_q[3].size() == 0) begin
                done = 1'b1;
            end
        end
        vec_cnt = vec_cnt + 1;
        if (!done) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s_drain: got %0d bytes pending, required 0 within %0d cycles", name, sb.size(), budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt = vec_cnt + 6;
        if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
        if (uart_tx_start !== 1'b0) begin err_cnt++; $display("FAIL reset_start: got %b, required 0", uart_tx_start); end
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (grant_id !== 2'd3) begin err_cnt++; $display("FAIL reset_grant: got %0d, required 3", grant_id); end
        if (pkt_abort !== 1'b0) begin err_cnt++; $display("FAIL reset_abort: got %b, required 0", pkt_abort); end
        if (uart_tx_data_in !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h, required 00", uart_tx_data_in); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset check done");
    endtask

    task automatic test_single();
        int ab0;
        ab0 = abort_cnt;
        start_cyc.delete();
        enqueue(1, 8'hAA, 1, 1'b0, 1'b1);
        enqueue(1, 8'h55, 1, 1'b1, 1'b1);
        wait_drain("single", 50);
        vec_cnt = vec_cnt + 3;
        if (start_cyc.size() != 2 || start_cyc[1] - start_cyc[0] != 1) begin
            err_cnt++;
            $display("FAIL single_consecutive: got %0d starts, required 2 on consecutive cycles", start_cyc.size());
        end
        if (grant_id !== 2'd1) begin err_cnt++; $display("FAIL single_grant: got %0d, required 1", grant_id); end
        if (abort_cnt != ab0) begin err_cnt++; $display("FAIL single_abort: got %0d, required 0", abort_cnt - ab0); end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_cyc.delete();
        enqueue(0, 8'h01, 3, 1'b1, 1'b0);
        enqueue(2, 8'h11, 3, 1'b1, 1'b0);
        sb_push(8'h01, 3);
        sb_push(8'h11, 3);
        wait_drain("rr_0_2", 60);
        vec_cnt = vec_cnt + 2;
        if (start_cyc.size() != 6 || start_cyc[3] - start_cyc[2] != 2) begin
            err_cnt++;
            $display("FAIL rr_gap: got %0d starts, required 6 with one idle cycle between packets", start_cyc.size());
        end
        if (grant_id !== 2'd2) begin err_cnt++; $display("FAIL rr_grant_a: got %0d, required 2", grant_id); end
        enqueue(0, 8'h21, 2, 1'b1, 1'b0);
        enqueue(3, 8'h31, 2, 1'b1, 1'b0);
        sb_push(8'h31, 2);
        sb_push(8'h21, 2);
        wait_drain("rr_0_3", 60);
        vec_cnt = vec_cnt + 1;
        if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL rr_grant_b: got %0d, required 0", grant_id); end
    endtask

    task automatic test_backpressure();
        int ab0;
        bit seen;
        ab0 = abort_cnt;
        start_cyc.delete();
        ff_mode = 1;
        enqueue(0, 8'h00, MP, 1'b1, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (start_cyc.size() >= 20) seen = 1'b1;
        end
        ff_mode = 2;
        repeat (ST + 9) @(posedge clk);
        @(negedge clk);
        vec_cnt = vec_cnt + 1;
        if (busy !== 1'b1 || !seen) begin
            err_cnt++;
            $display("FAIL full_not_stall: got busy=%b, required 1 after long FIFO full", busy);
        end
        ff_mode = 1;
        wait_drain("backpressure", 600);
        ff_mode = 0;
        vec_cnt = vec_cnt + 1;
        if (abort_cnt != ab0) begin err_cnt++; $display("FAIL bp_abort: got %0d, required 0 (last on byte MAX_PKT)", abort_cnt - ab0); end
    endtask

    task automatic test_max_pkt();
        int ab0;
        ab0 = abort_cnt;
        start_cyc.delete();
        enqueue(0, 8'h80, 80, 1'b1, 1'b0);
        sb_push(8'h80, MP);
        sb_push(8'hE0, 2);
        sb_push(8'h80 + 8'(MP), 80 - MP);
        for (int c = 0; c < 20 && busy !== 1'b1; c++) @(negedge clk);
        enqueue(1, 8'hE0, 2, 1'b1, 1'b0);
        wait_drain("max_pkt", 400);
        vec_cnt = vec_cnt + 3;
        if (abort_cnt - ab0 != 1) begin err_cnt++; $display("FAIL max_abort_cnt: got %0d, required 1", abort_cnt - ab0); end
        if (start_cyc.size() < MP || abort_cyc != start_cyc[MP-1] + 1) begin
            err_cnt++;
            $display("FAIL max_abort_time: got cycle %0d, required one after byte %0d", abort_cyc, MP);
        end
        if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL max_grant: got %0d, required 0", grant_id); end
    endtask

    task automatic test_stall();
        int ab0;
        bit seen;
        ab0 = abort_cnt;
        start_cyc.delete();
        stall_en[2] = 1'b1;
        stall_at[2] = 3;
        enqueue(2, 8'h90, 6, 1'b1, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (abort_cnt != ab0) seen = 1'b1;
        end
        vec_cnt = vec_cnt + 3;
        if (!seen) begin err_cnt++; $display("FAIL stall_abort: got none, required pkt_abort"); end
        if (start_cyc.size() != 3 || abort_cyc - start_cyc[2] != ST + 1) begin
            err_cnt++;
            $display("FAIL stall_time: got %0d starts, abort at cycle %0d, required 3 starts and abort %0d cycles after last", start_cyc.size(), abort_cyc, ST + 1);
        end
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL stall_idle: got busy=%b, required 0", busy); end
        stall_en[2] = 1'b0;
        wait_drain("stall", 60);
        vec_cnt = vec_cnt + 2;
        if (abort_cnt - ab0 != 1) begin err_cnt++; $display("FAIL stall_abort_cnt: got %0d, required 1", abort_cnt - ab0); end
        if (grant_id !== 2'd2) begin err_cnt++; $display("FAIL stall_grant: got %0d, required 2", grant_id); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        enqueue(0, 8'h40, 10, 1'b1, 1'b0);
        sb_push(8'h40, 4);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) seen = 1'b1;
        end
        rst_n = 1'b0;
        lane_q[0].delete();
        repeat (3) @(negedge clk);
        vec_cnt = vec_cnt + 5;
        if (!seen) begin err_cnt++; $display("FAIL rmid_prefix: got %0d pending, required 0", sb.size()); end
        if (req_ready !== 4'b0000 || uart_tx_start !== 1'b0) begin
            err_cnt++; $display("FAIL rmid_ready: got ready=%b start=%b, required 0000/0", req_ready, uart_tx_start);
        end
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        if (grant_id !== 2'd3) begin err_cnt++; $display("FAIL rmid_grant: got %0d, required 3", grant_id); end
        if (uart_tx_data_in !== 8'h00 || pkt_abort !== 1'b0) begin
            err_cnt++; $display("FAIL rmid_data: got data=%h abort=%b, required 00/0", uart_tx_data_in, pkt_abort);
        end
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        enqueue(0, 8'h70, 3, 1'b1, 1'b1);
        wait_drain("reset_mid", 40);
        vec_cnt = vec_cnt + 1;
        if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL rmid_fresh_grant: got %0d, required 0", grant_id); end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            stall_en[i] = 1'b0;
            stall_at[i] = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_max_pkt();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
